dcache_ctrl: RTL and testbench

- Blocking, direct-mapped, write-through, no-write-allocate data cache controller.
- Sits directly downstream of the memory-access stage and consumes its Dcache request signals (enable, read, width, address, sign).
- Returns aligned, extended load data and a pipeline stall.
- Drives a simple word-wide req/ack memory bus for line refills and write-through stores.

---
 rtl/dcache_mem_if.sv | 34 +++
 rtl/dcache_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_mem_if.sv
// -----------------------------------------------------------------------------
// dcache_mem_if
// Word-wide req/ack memory bus between the data cache controller and memory.
//   mem_req   : cache -> mem, request pending
//   mem_we    : cache -> mem, 1 = write, 0 = read
//   mem_addr  : cache -> mem, word-aligned byte address
//   mem_wdata : cache -> mem, lane-replicated store data
//   mem_wstrb : cache -> mem, byte enables
//   mem_ack   : mem -> cache, request completed (rdata valid in the same cycle)
//   mem_rdata : mem -> cache, read word
// Modports: master (cache side), slave (memory side).
// -----------------------------------------------------------------------------
interface dcache_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
// Blocking, direct-mapped, write-through, no-write-allocate data cache.
// Lines are 16 bytes (4 words); valid/tag/data are held in flops and read
// combinationally so load hits complete with zero latency.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   Mem_Dcache*       : request from the memory-access stage (EN, Rd, Width,
//                       Addr, Sign) plus Mem_StData (right-aligned store data)
//   Dcache_Rdata      : aligned, sign/zero-extended load result
//   Dcache_Stall      : hold the pipeline (request inputs held stable)
//   Dcache_Misalign   : misaligned access flag, no cache/bus activity
//   bus               : dcache_mem_if master (refills and write-through stores)
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int LINE_NUM   = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Mem_DcacheEN,
    input  logic                  Mem_DcacheRd,
    input  logic [1:0]            Mem_DcacheWidth,
    input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
    input  logic                  Mem_DcacheSign,
    input  logic [DATA_WIDTH-1:0] Mem_StData,
    output logic [DATA_WIDTH-1:0] Dcache_Rdata,
    output logic                  Dcache_Stall,
    output logic                  Dcache_Misalign,
    dcache_mem_if.master          bus
);
    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int TAG_W = ADDR_WIDTH - 4 - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, WSTORE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    // Word address of the outstanding refill/store (byte offset dropped).
    logic [ADDR_WIDTH-3:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;

    logic [LINE_NUM-1:0]     valid_q;
    logic [TAG_W-1:0]        tag_q  [LINE_NUM];
    logic [DATA_WIDTH-1:0]   data_q [LINE_NUM][4];

    // ---------------- request decode ----------------
    logic [IDX_W-1:0]      req_idx, fill_idx;
    logic [TAG_W-1:0]      req_tag, fill_tag;
    logic                  is_byte, is_half, misalign_c, req_go, hit;
    logic [DATA_WIDTH-1:0] rd_word, ld_data, st_data;
    logic [3:0]            st_strb;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;

    assign req_idx  = Mem_DcacheAddr[4 +: IDX_W];
    assign req_tag  = Mem_DcacheAddr[4 + IDX_W +: TAG_W];
    assign fill_idx = addr_q[2 +: IDX_W];
    assign fill_tag = addr_q[2 + IDX_W +: TAG_W];

    assign is_byte    = (Mem_DcacheWidth == 2'b00);
    assign is_half    = (Mem_DcacheWidth == 2'b01);
    // Width 11 is handled as a word everywhere.
    assign misalign_c = (is_half && Mem_DcacheAddr[0]) ||
                        (!is_byte && !is_half && (Mem_DcacheAddr[1:0] != 2'b00));
    assign req_go     = Mem_DcacheEN && !misalign_c;
    assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign rd_word  = data_q[req_idx][Mem_DcacheAddr[3:2]];
    assign sel_byte = rd_word[{Mem_DcacheAddr[1:0], 3'b000} +: 8];
    assign sel_half = rd_word[{Mem_DcacheAddr[1], 4'b0000} +: 16];

    always_comb begin
        if (is_byte) begin
            ld_data = Mem_DcacheSign ? {{24{sel_byte[7]}}, sel_byte} : {24'b0, sel_byte};
        end else if (is_half) begin
            ld_data = Mem_DcacheSign ? {{16{sel_half[15]}}, sel_half} : {16'b0, sel_half};
        end else begin
            ld_data = rd_word;
        end
    end

    // Store lanes: data replicated across the word, strobes pick the bytes.
    always_comb begin
        if (is_byte) begin
            st_strb = 4'b0001 << Mem_DcacheAddr[1:0];
            st_data = {4{Mem_StData[7:0]}};
        end else if (is_half) begin
            st_strb = 4'b0011 << Mem_DcacheAddr[1:0];
            st_data = {2{Mem_StData[15:0]}};
        end else begin
            st_strb = 4'b1111;
            st_data = Mem_StData;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            IDLE: begin
                if (req_go) begin
                    if (Mem_DcacheRd) begin
                        if (!hit) begin
                            state_d = REFILL;
                            cnt_d   = 2'd0;
                            addr_d  = Mem_DcacheAddr[ADDR_WIDTH-1:2];
                        end
                    end else begin
                        state_d = WSTORE;
                        addr_d  = Mem_DcacheAddr[ADDR_WIDTH-1:2];
                        wdata_d = st_data;
                        wstrb_d = st_strb;
                    end
                end
            end
            REFILL: begin
                if (bus.mem_ack) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = DONE;
                end
            end
            WSTORE: begin
                if (bus.mem_ack) state_d = DONE;
            end
            default: state_d = IDLE;   // DONE
        endcase
    end

    // ---------------- FSM: outputs ----------------
    logic                  clr_valid, set_valid, line_we;
    logic [IDX_W-1:0]      line_idx;
    logic [1:0]            line_word;
    logic [3:0]            line_strb;
    logic [DATA_WIDTH-1:0] line_wdata;

    always_comb begin
        Dcache_Rdata    = '0;
        Dcache_Stall    = 1'b0;
        Dcache_Misalign = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.mem_wstrb   = 4'b0000;
        clr_valid       = 1'b0;
        set_valid       = 1'b0;
        line_we         = 1'b0;
        line_idx        = req_idx;
        line_word       = Mem_DcacheAddr[3:2];
        line_strb       = st_strb;
        line_wdata      = st_data;
        case (state_q)
            IDLE: begin
                if (Mem_DcacheEN) begin
                    if (misalign_c) begin
                        Dcache_Misalign = 1'b1;
                    end else if (Mem_DcacheRd) begin
                        if (hit) begin
                            Dcache_Rdata = ld_data;
                        end else begin
                            Dcache_Stall = 1'b1;
                            // Invalidate up front so an aborted refill never
                            // leaves a half-filled line marked valid.
                            clr_valid    = 1'b1;
                        end
                    end else begin
                        Dcache_Stall = 1'b1;
                        line_we      = hit;   // update resident copy only
                    end
                end
            end
            REFILL: begin
                Dcache_Stall = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_addr = {addr_q[ADDR_WIDTH-3:2], cnt_q, 2'b00};
                line_idx     = fill_idx;
                line_word    = cnt_q;
                line_strb    = 4'b1111;
                line_wdata   = bus.mem_rdata;
                line_we      = bus.mem_ack;
                set_valid    = bus.mem_ack && (cnt_q == 2'd3);
            end
            WSTORE: begin
                Dcache_Stall  = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {addr_q, 2'b00};
                bus.mem_wdata = wdata_q;
                bus.mem_wstrb = wstrb_q;
            end
            default: begin   // DONE: the held request is answered from the array
                if (Mem_DcacheEN && Mem_DcacheRd) Dcache_Rdata = ld_data;
            end
        endcase
    end

    // ---------------- arrays ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clr_valid) begin
            valid_q[req_idx] <= 1'b0;
        end else if (set_valid) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (line_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (line_strb[b]) begin
                        data_q[line_idx][line_word][8*b +: 8] <= line_wdata[8*b +: 8];
                    end
                end
            end
            if (set_valid) begin
                tag_q[fill_idx] <= fill_tag;
            end
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
`timescale 1ns/1ps
module tb_dcache_ctrl;
    localparam int LINE_NUM = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, rd = 1'b0, sign = 1'b0;
    logic [1:0]  width = 2'b10;
    logic [31:0] addr = 32'h0, stdata = 32'h0;
    logic [31:0] rdata;
    logic        stall, misalign;

    dcache_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dcache_ctrl #(.LINE_NUM(LINE_NUM), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .Mem_DcacheEN    (en),
        .Mem_DcacheRd    (rd),
        .Mem_DcacheWidth (width),
        .Mem_DcacheAddr  (addr),
        .Mem_DcacheSign  (sign),
        .Mem_StData      (stdata),
        .Dcache_Rdata    (rdata),
        .Dcache_Stall    (stall),
        .Dcache_Misalign (misalign),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- memory: reference view and bus-side view ----------------
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] bus_mem [int unsigned];

    function automatic logic [31:0] seed_word(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] wa);
        if (!ref_mem.exists(wa)) ref_mem[wa] = seed_word(wa);
        return ref_mem[wa];
    endfunction

    function automatic logic [31:0] bus_word(input logic [31:0] wa);
        if (!bus_mem.exists(wa)) bus_mem[wa] = seed_word(wa);
        return bus_mem[wa];
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } txn_t;
    txn_t log_q[$];

    // ---------------- memory responder ----------------
    int lat_fix  = 2;   // -1 selects random latency 0..3
    int wait_cnt = 0;
    int cur_lat  = 2;

    always @(negedge clk) begin
        txn_t        t;
        logic [31:0] wa, w;
        if (rst || !bus.mem_req) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'hDEADBEEF;
            wait_cnt      = 0;
        end else if (wait_cnt >= cur_lat) begin
            wa = bus.mem_addr >> 2;
            if (bus.mem_we) begin
                w = bus_word(wa);
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                bus_mem[wa]   = w;
                bus.mem_rdata = 32'hDEADBEEF;
            end else begin
                bus.mem_rdata = bus_word(wa);
            end
            bus.mem_ack = 1'b1;
            t.we    = bus.mem_we;
            t.addr  = bus.mem_addr;
            t.wdata = bus.mem_wdata;
            t.strb  = bus.mem_wstrb;
            log_q.push_back(t);
            wait_cnt = 0;
            cur_lat  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
        end else begin
            bus.mem_ack = 1'b0;
            wait_cnt++;
        end
    end

    // ---------------- cache model: which line occupies each set ----------------
    int resident [LINE_NUM];

    // One pipeline access, checked against the model. Returns at posedge+1
    // with the controller back in IDLE.
    task automatic do_op(input logic r, input logic [1:0] w, input logic [31:0] a,
                         input logic s, input logic [31:0] d);
        logic        mis, exp_hit;
        logic [31:0] wa, line, word, exp_rd, wd, base;
        logic [3:0]  strb;
        int          set_i, cyc;
        string       nm;

        mis     = (w == 2'd1 && a[0]) || (w[1] && a[1:0] != 2'b00);
        wa      = a >> 2;
        line    = a >> 4;
        base    = line << 4;
        set_i   = int'(line % LINE_NUM);
        exp_hit = (resident[set_i] == int'(line));
        word    = ref_word(wa);
        if (w == 2'd0) begin
            exp_rd = (word >> (8 * a[1:0])) & 32'hFF;
            if (s && exp_rd[7]) exp_rd = exp_rd | 32'hFFFFFF00;
            strb = 4'b0001 << a[1:0];
            wd   = {4{d[7:0]}};
        end else if (w == 2'd1) begin
            exp_rd = (word >> (8 * a[1:0])) & 32'hFFFF;
            if (s && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF0000;
            strb = 4'b0011 << a[1:0];
            wd   = {2{d[15:0]}};
        end else begin
            exp_rd = word;
            strb   = 4'b1111;
            wd     = d;
        end
        nm = $sformatf("%s w%0d @%h", r ? "LD" : "ST", w, a);

        log_q.delete();
        @(negedge clk);
        en = 1'b1; rd = r; width = w; addr = a; sign = s; stdata = d;
        #1;
        if (mis) begin
            chk({nm, " misalign"}, misalign, 1);
            chk({nm, " mis_stall"}, stall, 0);
            chk({nm, " mis_rdata"}, rdata, 0);
            @(posedge clk); #1;
            chk({nm, " mis_nobus"}, log_q.size(), 0);
        end else if (r && exp_hit) begin
            chk({nm, " hit_misalign"}, misalign, 0);
            chk({nm, " hit_stall"}, stall, 0);
            chk({nm, " hit_rdata"}, rdata, exp_rd);
            @(posedge clk); #1;
            chk({nm, " hit_nobus"}, log_q.size(), 0);
        end else begin
            chk({nm, " stall_rise"}, stall, 1);
            chk({nm, " misalign"}, misalign, 0);
            cyc = 0;
            do begin
                @(posedge clk); #1;
                cyc++;
            end while (stall && cyc < 64);
            chk({nm, " stall_release"}, stall, 0);
            chk({nm, " req_drop"}, bus.mem_req, 0);
            if (r) begin
                chk({nm, " done_rdata"}, rdata, exp_rd);
                chk({nm, " refill_count"}, log_q.size(), 4);
                if (log_q.size() == 4)
                    for (int i = 0; i < 4; i++) begin
                        chk($sformatf("%s refill_addr%0d", nm, i), log_q[i].addr, base + 32'(4 * i));
                        chk($sformatf("%s refill_we%0d", nm, i), log_q[i].we, 0);
                    end
                resident[set_i] = int'(line);
            end else begin
                chk({nm, " store_count"}, log_q.size(), 1);
                if (log_q.size() == 1) begin
                    chk({nm, " store_we"}, log_q[0].we, 1);
                    chk({nm, " store_addr"}, log_q[0].addr, wa << 2);
                    chk({nm, " store_wdata"}, log_q[0].wdata, wd);
                    chk({nm, " store_wstrb"}, log_q[0].strb, strb);
                end
                for (int b = 0; b < 4; b++)
                    if (strb[b]) word[8*b +: 8] = wd[8*b +: 8];
                ref_mem[wa] = word;
            end
            @(negedge clk);
            en = 1'b0;
            @(posedge clk); #1;
        end
        $display("txn %s hit=%0d mis=%0d rdata=%h bus=%0d", nm, exp_hit, mis, rdata, log_q.size());
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < LINE_NUM; i++) resident[i] = -1;
        ref_mem[32'h40] = 32'h11111111;  bus_mem[32'h40] = 32'h11111111;
        ref_mem[32'h41] = 32'h22222222;  bus_mem[32'h41] = 32'h22222222;
        ref_mem[32'h42] = 32'h33333333;  bus_mem[32'h42] = 32'h33333333;
        ref_mem[32'h43] = 32'h88448044;  bus_mem[32'h43] = 32'h88448044;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_wstrb", bus.mem_wstrb, 0);
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset released");

        // Directed plan
        lat_fix = 2;
        do_op(1, 2'd2, 32'h100, 0, 0);            // cold LW -> 0x11111111
        do_op(1, 2'd0, 32'h10D, 1, 0);            // LB  -> FFFFFF80
        do_op(1, 2'd0, 32'h10D, 0, 0);            // LBU -> 00000080
        do_op(1, 2'd1, 32'h10E, 1, 0);            // LH  -> FFFF8844
        do_op(0, 2'd0, 32'h101, 0, 32'h000000AB); // SB hit
        do_op(1, 2'd2, 32'h100, 0, 0);            // LW hit -> 1111AB11
        do_op(0, 2'd1, 32'h202, 0, 32'h00001234); // SH miss
        do_op(1, 2'd2, 32'h200, 0, 0);            // LW miss (no allocate)
        do_op(1, 2'd2, 32'h102, 0, 0);            // misaligned LW
        do_op(0, 2'd1, 32'h101, 0, 32'h5555);     // misaligned SH
        do_op(1, 2'd3, 32'h104, 0, 0);            // width 11 as word, hit

        // Reset in the middle of a refill
        log_q.delete();
        @(negedge clk);
        en = 1'b1; rd = 1'b1; width = 2'd2; addr = 32'h300; sign = 1'b0;
        #1;
        chk("mid_rst stall_rise", stall, 1);
        cyc = 0;
        while (log_q.size() < 2 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_rst acks_seen", log_q.size(), 2);
        #1;
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst req", bus.mem_req, 0);
        chk("mid_rst stall", stall, 0);
        chk("mid_rst rdata", rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < LINE_NUM; i++) resident[i] = -1;
        $display("txn reset during refill");
        do_op(1, 2'd2, 32'h100, 0, 0);            // full refill again -> 1111AB11

        // Randomized traffic
        lat_fix = -1;
        for (int n = 0; n < 200; n++) begin
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  32'($urandom_range(0, 32'hFFF)), 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
